// File: rtl/keypad_event_ctrl.sv
// Debounces the keypad scanner's code/valid stream and queues one event per qualified press
// in a first-word-fall-through FIFO. Define KEYPAD_REPEAT_EN to add auto-repeat while held.
module keypad_event_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REPEAT_DELAY    = 32,
    parameter int unsigned REPEAT_RATE     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          scan_valid,
    input  logic [3:0]                    scan_code,
    input  logic                          clear,
    output logic                          evt_valid,
    output logic [3:0]                    evt_code,
    input  logic                          evt_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cap_q, cap_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            restart;
    logic            fsm_push;
    logic            rpt_push;
    logic            push;

    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      last_q;
    logic            ovf_q;
    logic            full;
    logic            pop;
    logic            wr;

    // ---------------------------------------------------------------------------------------
    // Debounce FSM
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        restart  = 1'b0;
        fsm_push = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (scan_valid) begin
                    restart = 1'b1;
                end
            end
            StDebounce: begin
                if (!scan_valid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (scan_code != cap_q) begin
                    restart = 1'b1;
                end else if (cnt_q + DW'(1) == DW'(DEBOUNCE_CYCLES)) begin
                    fsm_push = 1'b1;
                    state_d  = StHeld;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            StHeld: begin
                if (!scan_valid) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        state_d = StRelease;
                        cnt_d   = DW'(1);
                    end
                end else if (scan_code != cap_q) begin
                    restart = 1'b1;
                end
            end
            StRelease: begin
                if (!scan_valid) begin
                    if (cnt_q + DW'(1) == DW'(DEBOUNCE_CYCLES)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end else if (scan_code == cap_q) begin
                    // Release bounce: the key is still down, no new event.
                    state_d = StHeld;
                    cnt_d   = '0;
                end else begin
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // A newly seen code starts qualification from one sample.
        if (restart) begin
            cap_d = scan_code;
            if (DEBOUNCE_CYCLES == 1) begin
                fsm_push = 1'b1;
                state_d  = StHeld;
                cnt_d    = '0;
            end else begin
                state_d = StDebounce;
                cnt_d   = DW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q <= StIdle;
            cap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Auto-repeat
    // ---------------------------------------------------------------------------------------
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_phase_q, rpt_phase_d;
    logic [RW-1:0] rpt_target;

    assign rpt_target = rpt_phase_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

    // Counter only survives cycles that stay in HELD on the same key.
    always_comb begin
        rpt_d       = '0;
        rpt_phase_d = 1'b0;
        rpt_push    = 1'b0;
        if (state_q == StHeld && scan_valid && scan_code == cap_q) begin
            if (rpt_q + RW'(1) == rpt_target) begin
                rpt_push    = 1'b1;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_d       = rpt_q + RW'(1);
                rpt_phase_d = rpt_phase_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rpt_q       <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rpt_push = 1'b0;
`endif

    assign push = fsm_push | rpt_push;

    // ---------------------------------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------------------------------
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr        = push & (~full | pop);

    // While empty the output keeps the last head that was presented.
    assign evt_code   = evt_valid ? mem_q[rptr_q] : last_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= evt_code;
            if (wr) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr && !reset && !clear) begin
            mem_q[wptr_q] <= cap_d;
        end
    end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Self-checking bench for keypad_event_ctrl: directed plan steps plus random key traffic,
// compared every cycle against a run-length based reference model.
module tb_keypad_event_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DELAY = 32;
    localparam int unsigned RATE  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scan_valid = 1'b0;
    logic [3:0] scan_code = 4'h0;
    logic       clear = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       overflow;
    logic [2:0] fifo_count;

    keypad_event_ctrl #(
        .DEBOUNCE_CYCLES(N),
        .FIFO_DEPTH     (DEPTH),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_RATE    (RATE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .clear     (clear),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: queue of events, key considered "down" once N identical samples seen.
    logic [3:0] mq[$];
    bit         m_ovf;
    logic [3:0] m_last;
    bit         m_down;
    logic [3:0] m_key;
    bit         m_have_prev;
    bit         m_prev_v;
    logic [3:0] m_prev_c;
    int         m_run;
    int         m_hold;

    logic [3:0] seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit v, input logic [3:0] c, input bit clr, input bit rdy,
                              input bit rst);
        bit push;
        bit pop;
        int sz0;
        if (rst || clr) begin
            mq.delete();
            m_ovf       = 1'b0;
            m_last      = 4'h0;
            m_down      = 1'b0;
            m_have_prev = 1'b0;
            m_run       = 0;
            m_hold      = 0;
            return;
        end
        push = 1'b0;
        if (m_have_prev && m_prev_v == v && (!v || m_prev_c == c)) m_run++;
        else m_run = 1;
        m_have_prev = 1'b1;
        m_prev_v    = v;
        m_prev_c    = c;
        if (v) begin
            if (m_down && m_key == c) begin
                m_hold = (m_run == 1) ? 0 : m_hold + 1;
`ifdef KEYPAD_REPEAT_EN
                if (m_hold == DELAY || (m_hold > DELAY && (m_hold - DELAY) % RATE == 0))
                    push = 1'b1;
`endif
            end else begin
                m_down = 1'b0;
                if (m_run == N) begin
                    push   = 1'b1;
                    m_down = 1'b1;
                    m_key  = c;
                    m_hold = 0;
                end
            end
        end else if (m_down && m_run == N) begin
            m_down = 1'b0;
        end
        sz0 = mq.size();
        pop = (sz0 > 0) && rdy;
        if (pop) m_last = mq.pop_front();
        if (push) begin
            if (sz0 == DEPTH && !pop) m_ovf = 1'b1;
            else mq.push_back(c);
        end
    endtask

    task automatic cyc(input bit v, input logic [3:0] c, input bit clr, input bit rdy);
        logic [3:0] exp_code;
        scan_valid = v;
        scan_code  = c;
        clear      = clr;
        evt_ready  = rdy;
        if (evt_valid && evt_ready && !reset && !clr) seen.push_back(evt_code);
        @(posedge clock);
        model_step(v, c, clr, rdy, reset);
        #1;
        exp_code = (mq.size() != 0) ? mq[0] : m_last;
        chk("evt_valid", evt_valid, mq.size() != 0);
        chk("evt_code", evt_code, exp_code);
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic press(input logic [3:0] c, input int hi, input int lo, input bit rdy);
        for (int i = 0; i < hi; i++) cyc(1'b1, c, 1'b0, rdy);
        for (int i = 0; i < lo; i++) cyc(1'b0, 4'h0, 1'b0, rdy);
    endtask

    bit         rv;
    logic [3:0] rc;
    int         rlen;
    int         exp6;

    initial begin
        // Reset state
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("reset_count", fifo_count, 0);
        chk("reset_valid", evt_valid, 0);
        reset = 1'b0;

        // 1: single press, latency and one-cycle valid with ready high
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 4'h5, 1'b0, 1'b1);
            if (i == 2) chk("t1_not_yet", evt_valid, 0);
            if (i == 3) chk("t1_latency", evt_valid, 1);
            if (i == 4) chk("t1_one_cycle", evt_valid, 0);
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t1_events", seen.size(), 1);
        if (seen.size() > 0) chk("t1_code", seen[0], 4'h5);
        chk("t1_count", fifo_count, 0);

        // 2: glitch shorter than debounce
        seen.delete();
        press(4'h3, 3, 8, 1'b1);
        chk("t2_events", seen.size(), 0);
        chk("t2_count", fifo_count, 0);

        // 3: release bounce
        seen.delete();
        press(4'h7, 10, 2, 1'b1);
        press(4'h7, 5, 10, 1'b1);
        chk("t3_events", seen.size(), 1);
        if (seen.size() > 0) chk("t3_code", seen[0], 4'h7);

        // 4: overflow with consumer stalled
        seen.delete();
        for (int k = 1; k <= 5; k++) press(4'(k), 10, 10, 1'b0);
        chk("t4_full", fifo_count, 4);
        chk("t4_ovf", overflow, 1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t4_events", seen.size(), 4);
        for (int k = 0; k < 4; k++) if (seen.size() > k) chk("t4_order", seen[k], 4'(k + 1));
        chk("t4_ovf_sticky", overflow, 1);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        chk("t4_ovf_clear", overflow, 0);

        // 5: clear with two queued and a press mid-debounce
        press(4'h8, 10, 10, 1'b0);
        press(4'h9, 10, 10, 1'b0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 4'hA, 1'b1, 1'b0);
        chk("t5_count", fifo_count, 0);
        chk("t5_valid", evt_valid, 0);
        chk("t5_ovf", overflow, 0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        chk("t5_no_resume", fifo_count, 0);
        seen.delete();
        press(4'h0, 0, 10, 1'b1);
        chk("t5_events", seen.size(), 0);

        // 6: long hold
`ifdef KEYPAD_REPEAT_EN
        exp6 = 6;
`else
        exp6 = 1;
`endif
        seen.delete();
        press(4'hA, 4 + 70, 10, 1'b1);
        chk("t6_events", seen.size(), exp6);
        if (seen.size() > 0) chk("t6_code", seen[0], 4'hA);

        // Random traffic: small code set for collisions, occasional long holds and clears
        for (int s = 0; s < 80; s++) begin
            rv   = ($urandom_range(0, 2) != 0);
            rc   = 4'($urandom_range(0, 3));
            rlen = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 50) : $urandom_range(1, 12);
            for (int i = 0; i < rlen; i++)
                cyc(rv, rc, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
